// File: rtl/ff_pin_bank_if.sv
// ff_pin_bank_if: tester-cycle timing, vector stream and pin outputs of ff_pin_bank.
// The master modport belongs to the pattern source and the slave modport to ff_pin_bank.
// The cycle_cnt signal exists only when FF_PIN_BANK_CYCLE_CNT_EN is defined.
interface ff_pin_bank_if #(
  parameter int NCH = 8,
  parameter int TW  = 8
);
  logic               run;
  logic [TW-1:0]      period;
  logic [TW-1:0]      t_lead;
  logic [TW-1:0]      t_trail;
  logic [2*NCH-1:0]   ff;
  logic [NCH-1:0]     vec_d;
  logic               vec_valid;
  logic               vec_ready;
  logic [NCH-1:0]     q;
  logic               cyc;
  logic               underrun;
`ifdef FF_PIN_BANK_CYCLE_CNT_EN
  logic [15:0]        cycle_cnt;
`endif

  modport master (
    output run, period, t_lead, t_trail, ff, vec_d, vec_valid,
    input  vec_ready, q, cyc, underrun
`ifdef FF_PIN_BANK_CYCLE_CNT_EN
    , input cycle_cnt
`endif
  );

  modport slave (
    input  run, period, t_lead, t_trail, ff, vec_d, vec_valid,
    output vec_ready, q, cyc, underrun
`ifdef FF_PIN_BANK_CYCLE_CNT_EN
    , output cycle_cnt
`endif
  );
endinterface

// File: rtl/ff_pin_bank.sv
// ff_pin_bank: tester pin bank. A tick counter divides time into tester cycles of
// period+1 clocks. At tick 0 each cycle takes the next vector from a 2-entry buffer, and
// every channel turns its bit into a pin waveform: return-to-zero, return-to-one, or
// delayed NRZ launched at the leading or at the trailing edge.
// Optional feature: define FF_PIN_BANK_CYCLE_CNT_EN to add a 16-bit count of started cycles.
module ff_pin_bank #(
  parameter int NCH = 8,
  parameter int TW  = 8
) (
  input  logic         clk,
  input  logic         rst,
  ff_pin_bank_if.slave bus
);

  typedef enum logic [1:0] {
    FMT_R0     = 2'b00,
    FMT_R1     = 2'b01,
    FMT_DNRZ_L = 2'b10,
    FMT_DNRZ_T = 2'b11
  } fmt_e;

  logic [TW-1:0]  cnt;
  logic [NCH-1:0] fifo_mem [2];
  logic           rd_ptr;
  logic           wr_ptr;
  logic [1:0]     occ;
  logic [NCH-1:0] a_reg;
  logic [NCH-1:0] q_reg;
  logic           cyc_reg;
  logic           underrun_reg;

  logic           tick0;
  logic           push;
  logic           pop;
  logic [NCH-1:0] a_cur;
  logic           cyc_next;
  logic           lead_hit;
  logic           trail_hit;
  logic [NCH-1:0] q_next;

  // Handshake and tick decode; the vector popped at tick 0 is used on that same tick.
  assign tick0     = bus.run && (cnt == '0);
  assign push      = bus.vec_valid && (occ < 2'd2);
  assign pop       = tick0 && (occ != 2'd0);
  assign a_cur     = pop ? fifo_mem[rd_ptr] : a_reg;
  assign cyc_next  = bus.run && (bus.t_lead <= cnt) && (cnt < bus.t_trail);
  assign lead_hit  = bus.run && (cnt == bus.t_lead);
  assign trail_hit = bus.run && (cnt == bus.t_trail);

  // Per-channel waveform formatting for the current tick.
  always_comb begin
    // NOTE: the default assignment first keeps every path assigned, so no latch is inferred.
    q_next = q_reg;
    for (int i = 0; i < NCH; i++) begin
      case (fmt_e'(bus.ff[2*i +: 2]))
        FMT_R0:     q_next[i] = cyc_next ? a_cur[i] : 1'b0;
        FMT_R1:     q_next[i] = cyc_next ? a_cur[i] : 1'b1;
        FMT_DNRZ_L: if (lead_hit)  q_next[i] = a_cur[i];
        FMT_DNRZ_T: if (trail_hit) q_next[i] = a_cur[i];
        default:    q_next[i] = q_reg[i];
      endcase
    end
  end

  // Buffer storage is written only through push; stale entries are never read.
  // NOTE: the data array has no reset -- occupancy and pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.vec_d;
  end

  // Tick counter, buffer control, active vector and registered pin outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
      cnt          <= '0;
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      occ          <= 2'd0;
      a_reg        <= '0;
      q_reg        <= '0;
      cyc_reg      <= 1'b0;
      underrun_reg <= 1'b0;
    end else begin
      if (!bus.run)              cnt <= '0;
      else if (cnt >= bus.period) cnt <= '0;
      else                       cnt <= cnt + 1'b1;

      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase

      a_reg   <= a_cur;
      q_reg   <= q_next;
      cyc_reg <= cyc_next;
      if (tick0 && (occ == 2'd0)) underrun_reg <= 1'b1;
    end
  end

  assign bus.vec_ready = (occ < 2'd2);
  assign bus.q         = q_reg;
  assign bus.cyc       = cyc_reg;
  assign bus.underrun  = underrun_reg;

`ifdef FF_PIN_BANK_CYCLE_CNT_EN
  logic [15:0] cycle_cnt_reg;

  // Count of started tester cycles, wrapping naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        cycle_cnt_reg <= 16'd0;
    else if (tick0) cycle_cnt_reg <= cycle_cnt_reg + 16'd1;
  end

  assign bus.cycle_cnt = cycle_cnt_reg;
`endif

endmodule

// File: tb/tb_ff_pin_bank.sv
// tb_ff_pin_bank: self-checking bench for ff_pin_bank (NCH=4, TW=8).
// A reference model predicts each clock's outputs into a scoreboard queue; the entry is
// popped and compared against the DUT one time step after the edge.
module tb_ff_pin_bank;
  localparam int NCH = 4;
  localparam int TW  = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ff_pin_bank_if #(.NCH(NCH), .TW(TW)) bus ();
  ff_pin_bank #(.NCH(NCH), .TW(TW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [NCH-1:0] q;
    logic           cyc;
    logic           underrun;
    logic           ready;
    logic [15:0]    ccnt;
  } exp_t;

  exp_t           sb[$];
  logic [NCH-1:0] pend[$];
  logic [NCH-1:0] m_fifo[$];
  int             m_cnt;
  logic [NCH-1:0] m_a, m_q;
  logic           m_cyc, m_under;
  logic [15:0]    m_ccnt;
  int             n_checks = 0;
  int             n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_fifo.delete(); pend.delete(); sb.delete();
    m_a = '0; m_q = '0; m_cyc = 1'b0; m_under = 1'b0; m_ccnt = 16'd0;
  endtask

  // Async reset: outputs must clear before any clock edge arrives.
  task automatic do_reset();
    bus.vec_valid = 1'b0;
    rst = 1'b1;
    #2;
    model_reset();
    check("rst_q", 32'(bus.q), 32'd0);
    check("rst_cyc", 32'(bus.cyc), 32'd0);
    check("rst_underrun", 32'(bus.underrun), 32'd0);
    check("rst_ready", 32'(bus.vec_ready), 32'd1);
`ifdef FF_PIN_BANK_CYCLE_CNT_EN
    check("rst_cycle_cnt", 32'(bus.cycle_cnt), 32'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // One clock: drive the next pending vector, predict, clock, then compare.
  task automatic step();
    exp_t e;
    bit   accept;
    int   k;
    bus.vec_valid = (pend.size() > 0);
    bus.vec_d     = (pend.size() > 0) ? pend[0] : '0;
    accept = bus.vec_valid && (m_fifo.size() < 2);
    k = m_cnt;
    if (bus.run && k == 0) begin
      if (m_fifo.size() > 0) m_a = m_fifo.pop_front();
      else                   m_under = 1'b1;
      m_ccnt = m_ccnt + 16'd1;
    end
    if (accept) m_fifo.push_back(pend.pop_front());
    m_cyc = bus.run && (int'(bus.t_lead) <= k) && (k < int'(bus.t_trail));
    for (int i = 0; i < NCH; i++) begin
      case (bus.ff[2*i +: 2])
        2'b00: m_q[i] = m_cyc & m_a[i];
        2'b01: m_q[i] = m_cyc ? m_a[i] : 1'b1;
        2'b10: if (bus.run && k == int'(bus.t_lead))  m_q[i] = m_a[i];
        default: if (bus.run && k == int'(bus.t_trail)) m_q[i] = m_a[i];
      endcase
    end
    m_cnt = !bus.run ? 0 : ((k >= int'(bus.period)) ? 0 : k + 1);
    e.q = m_q; e.cyc = m_cyc; e.underrun = m_under;
    e.ready = (m_fifo.size() < 2); e.ccnt = m_ccnt;
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    check("q", 32'(bus.q), 32'(e.q));
    check("cyc", 32'(bus.cyc), 32'(e.cyc));
    check("underrun", 32'(bus.underrun), 32'(e.underrun));
    check("vec_ready", 32'(bus.vec_ready), 32'(e.ready));
`ifdef FF_PIN_BANK_CYCLE_CNT_EN
    check("cycle_cnt", 32'(bus.cycle_cnt), 32'(e.ccnt));
`endif
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_timing(input int per, input int tl, input int tt, input logic [2*NCH-1:0] fmt);
    bus.period = TW'(per); bus.t_lead = TW'(tl); bus.t_trail = TW'(tt); bus.ff = fmt;
  endtask

  initial begin
    bus.run = 1'b0; bus.vec_valid = 1'b0; bus.vec_d = '0;
    set_timing(9, 2, 6, 8'h00);
    #1;
    do_reset();

    // All R0: Q=1011 inside ticks 2..5, 0 elsewhere; the second cycle underruns and repeats.
    pend.push_back(4'b1011);
    step();
    bus.run = 1'b1;
    steps(3);
    check("r0_win_q", 32'(bus.q), 32'hB);
    check("r0_win_cyc", 32'(bus.cyc), 32'd1);
    steps(17);
    bus.run = 1'b0;
    steps(2);

    // ch0 R1, ch1 DNRZ_L, others R0; vectors {ch1,ch0} = 01 then 10.
    do_reset();
    set_timing(9, 2, 6, 8'b00_00_10_01);
    pend.push_back(4'b0001); pend.push_back(4'b0010);
    steps(2);
    bus.run = 1'b1;
    steps(20);
    bus.run = 1'b0;
    steps(2);

    // All DNRZ_T, vectors 1,0,1 then underrun in the 4th cycle.
    do_reset();
    set_timing(9, 2, 6, 8'hFF);
    pend.push_back(4'hF); pend.push_back(4'h0); pend.push_back(4'hF);
    steps(2);
    check("full_ready", 32'(bus.vec_ready), 32'd0);
    bus.run = 1'b1;
    steps(40);
    check("underrun_sticky", 32'(bus.underrun), 32'd1);
    check("dnrz_t_hold", 32'(bus.q), 32'hF);
    bus.run = 1'b0;
    steps(2);

    // PERIOD=0: a new vector every clock with zero latency.
    do_reset();
    set_timing(0, 0, 1, 8'h00);
    for (int i = 0; i < 24; i++) pend.push_back(NCH'($urandom));
    step();
    bus.run = 1'b1;
    steps(20);
    bus.run = 1'b0;
    steps(2);

    // Reset at tick 4 with two vectors buffered, then restart from tick 0.
    do_reset();
    set_timing(9, 2, 6, 8'h00);
    pend.push_back(4'h3); pend.push_back(4'h5); pend.push_back(4'h9);
    steps(2);
    bus.run = 1'b1;
    steps(4);
    do_reset();
    pend.push_back(4'b0110);
    bus.run = 1'b0;
    step();
    bus.run = 1'b1;
    steps(4);
    check("post_rst_q", 32'(bus.q), 32'h6);
    steps(8);

    // Random formats, timing (edges may exceed PERIOD) and RUN gaps.
    do_reset();
    for (int r = 0; r < 6; r++) begin
      set_timing($urandom_range(0, 7), $urandom_range(0, 9), $urandom_range(0, 9),
                 (2*NCH)'($urandom));
      for (int i = 0; i < 50; i++) begin
        if (pend.size() < 3 && $urandom_range(0, 2) != 0) pend.push_back(NCH'($urandom));
        bus.run = ($urandom_range(0, 9) != 0);
        step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
